vmp_row_scheduler: RTL and testbench
====================================

# vmp_row_scheduler

Sequencer that time-multiplexes one shared `DotProduct` unit across the N output rows of the classifier's vector-matrix product. On `start` it latches the pixel vector and issues one weight-row index per cycle to the weight memory/DotProduct pipeline. It collects the N 26-bit results into a result buffer and tracks the running argmax. When finished it reports the winning class and raises `done`.

## Interface
Parameters:
- `N`, 10, number of output rows (classes)
- `PIXEL_N`, 10, pixels per vector
- `PIXEL_SIZE`, 10, bits per pixel
- `VAL_W`, 26, DotProduct result width (signed)
- `DP_LATENCY`, 3, cycles from `row_addr`/`issue` to matching `dp_value` (weight read plus DotProduct), at least 1
- `IDX_W`, `$clog2(N)`, row/class index width

Ports:
- `clk`, in, 1, sole clock, rising edge
- `GlobalReset`, in, 1, synchronous, active-low reset
- `start`, in, 1, begin a pass; sampled only in IDLE
- `Pixels`, in, PIXEL_N*PIXEL_SIZE, input vector; sampled on accepted `start`
- `pix_out`, out, PIXEL_N*PIXEL_SIZE, latched vector to DotProduct; held for the whole pass
- `row_addr`, out, IDX_W, weight-row index to weight memory
- `issue`, out, 1, `row_addr` valid this cycle
- `dp_value`, in, VAL_W, signed result, valid DP_LATENCY cycles after its `issue`
- `busy`, out, 1, high from the accepted `start` until `done`
- `done`, out, 1, one-cycle pulse; pass complete
- `class_idx`, out, IDX_W, argmax row of the last completed pass
- `max_value`, out, VAL_W, value at `class_idx`
- `rd_addr`, in, IDX_W, result buffer read index
- `rd_data`, out, VAL_W, combinational read of result buffer[`rd_addr`]

## Operation
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- **IDLE**
  - `start`=1: latch `Pixels` into `pix_out`, clear the issue counter, capture counter and argmax, then go to ISSUE.
  - `start` in any other state is ignored.
- **ISSUE**
  - Assert `issue` with `row_addr` equal to the issue counter.
  - Increment the counter each cycle.
  - After issuing row N-1, go to DRAIN.
- **DRAIN**
  - `issue`=0.
  - Stay until the capture counter reaches N, then go to DONE.
- **DONE**
  - `done`=1 for one cycle.
  - `class_idx` and `max_value` update from the argmax registers.
  - Go to IDLE.
- **Capture**
  - A DP_LATENCY-deep shift register carries `issue` and its row index.
  - When the tail is valid: write `dp_value` to buffer[row], increment the capture counter, and update the argmax.
  - Capture is independent of FSM state.
- **Argmax**
  - Signed compare.
  - Replace only on strictly greater, so ties keep the lower index.
  - Row 0 is loaded unconditionally.
- **Result buffer**
  - Retains its contents until overwritten by the next pass.
  - `rd_addr` ≥ N returns 0.
- `class_idx`/`max_value` hold their values across later passes until the next DONE.
- **Reset** (`GlobalReset`=0 at an edge), in any state, including mid-pass:
  - FSM returns to IDLE.
  - Counters, the valid pipeline, `issue`, `busy`, `done`, `class_idx`, `max_value`, `pix_out` and the buffer all go to 0.
  - In-flight results are discarded.

## Timing
- `start` sampled at edge 0; `busy`=1 from cycle 1.
- `issue`=1 during cycles 1..N, carrying rows 0..N-1.
- Row k's result is captured at the edge ending cycle 1+k+DP_LATENCY.
- DRAIN runs cycles N+1 .. N+DP_LATENCY.
- `done`=1 in cycle N+DP_LATENCY+1, with new `class_idx`/`max_value` visible in that cycle. `busy` falls at the end of that cycle.
- Pass length is N+DP_LATENCY+1 cycles (14 with defaults).
- `start` held high: the next pass is accepted in the IDLE cycle after DONE, one idle cycle between passes.
- `rd_data` has zero latency, combinational from buffer registers.

## Structure
- Shared package `vmp_pkg` holds:
  - FSM state encoding (IDLE=0, ISSUE=1, DRAIN=2, DONE=3)
  - `VAL_W`
  - default `N`, `PIXEL_N`, `PIXEL_SIZE`, `WEIGHT_SIZE`, `DP_LATENCY`
- One sub-module, `argmax_tracker`:
  - Inputs: valid, index, signed value, clear.
  - Outputs: best index and best value.
- Valid/index delay line and buffer stay in the top level.

## Test plan
- **Single pass, distinct values.** Model returns 100·(k+1) for row k, DP_LATENCY=3.
  - `done` in cycle 14 (start at edge 0).
  - `class_idx`=9, `max_value`=1000.
  - `rd_data`[4]=500.
- **Negatives and tie.** Rows return -50 except rows 3 and 7, both 20.
  - `class_idx`=3, `max_value`=20.
  - All-negative variant (row 5 = -1, others -9): `class_idx`=5.
- **Start while busy.** Pulse `start` in cycle 5 with different `Pixels`.
  - Ignored; `pix_out` unchanged.
  - Exactly one `done`, in cycle 14.
- **Back-to-back.** `start` held high for two passes.
  - Second pass's `issue` begins in cycle 16.
  - Two `done` pulses, 15 cycles apart.
  - Buffer reflects pass 2.
- **Reset mid-pass.** `GlobalReset`=0 in cycle 6.
  - Next cycle: IDLE, `busy`=0, `class_idx`=0, buffer zeroed.
  - No `done`, and no capture from in-flight rows.
  - A new pass afterwards completes normally.
- **Latency sweep.** DP_LATENCY=1 and 6.
  - `done` in cycles 12 and 17.
  - `issue` high for exactly N cycles each.

Source files
------------

// File: rtl/vmp_pkg.sv
// vmp_pkg: definitions shared by the vector-matrix-product row scheduler.
//   state_t               : scheduler FSM encoding (IDLE=0, ISSUE=1, DRAIN=2, DONE=3)
//   VAL_W                 : DotProduct result width (signed)
//   *_DEFAULT             : default geometry and pipeline depth of the classifier
package vmp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int VAL_W               = 26;
  localparam int N_DEFAULT           = 10;
  localparam int PIXEL_N_DEFAULT     = 10;
  localparam int PIXEL_SIZE_DEFAULT  = 10;
  localparam int WEIGHT_SIZE_DEFAULT = 8;
  localparam int DP_LATENCY_DEFAULT  = 3;

endpackage

// File: rtl/vmp_row_scheduler_if.sv
// vmp_row_scheduler_if: all non-clock/reset signals of the row scheduler.
//   master : scheduler side (drives pix_out/row_addr/issue, status, results)
//   slave  : environment side (start/Pixels, DotProduct result, buffer read index)
// Signals: start, Pixels, pix_out, row_addr, issue, dp_value, busy, done,
//          class_idx, max_value, rd_addr, rd_data.
interface vmp_row_scheduler_if #(
  parameter int N          = vmp_pkg::N_DEFAULT,
  parameter int PIXEL_N    = vmp_pkg::PIXEL_N_DEFAULT,
  parameter int PIXEL_SIZE = vmp_pkg::PIXEL_SIZE_DEFAULT,
  parameter int VAL_W      = vmp_pkg::VAL_W,
  parameter int IDX_W      = $clog2(N)
);

  logic                               start;
  logic [PIXEL_N*PIXEL_SIZE-1:0]      Pixels;
  logic [PIXEL_N*PIXEL_SIZE-1:0]      pix_out;
  logic [IDX_W-1:0]                   row_addr;
  logic                               issue;
  logic signed [VAL_W-1:0]            dp_value;
  logic                               busy;
  logic                               done;
  logic [IDX_W-1:0]                   class_idx;
  logic signed [VAL_W-1:0]            max_value;
  logic [IDX_W-1:0]                   rd_addr;
  logic signed [VAL_W-1:0]            rd_data;

  modport master (
    input  start, Pixels, dp_value, rd_addr,
    output pix_out, row_addr, issue, busy, done, class_idx, max_value, rd_data
  );

  modport slave (
    output start, Pixels, dp_value, rd_addr,
    input  pix_out, row_addr, issue, busy, done, class_idx, max_value, rd_data
  );

endinterface

// File: rtl/vmp_row_scheduler_argmax_tracker.sv
// argmax_tracker: running signed argmax over a stream of (index, value) results.
//   clk, rst_n     : clock, synchronous active-low reset
//   clear          : restart tracking for a new pass
//   valid/index/value : one result per cycle when valid
//   best_index/best_value : current winner
// Index 0 always loads so the first row seeds the search; afterwards only a
// strictly greater value replaces the winner, so ties keep the lower index.
module argmax_tracker #(
  parameter int IDX_W = 4,
  parameter int VAL_W = vmp_pkg::VAL_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear,
  input  logic                    valid,
  input  logic [IDX_W-1:0]        index,
  input  logic signed [VAL_W-1:0] value,
  output logic [IDX_W-1:0]        best_index,
  output logic signed [VAL_W-1:0] best_value
);
  import vmp_pkg::*;

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      best_index <= '0;
      best_value <= '0;
    end else if (valid && ((index == '0) || (value > best_value))) begin
      best_index <= index;
      best_value <= value;
    end
  end

endmodule

// File: rtl/vmp_row_scheduler.sv
// vmp_row_scheduler: time-multiplexes one DotProduct unit across N rows.
//   clk         : clock (rising edge)
//   GlobalReset : synchronous active-low reset
//   bus         : vmp_row_scheduler_if.master (start/Pixels in, row_addr/issue
//                 to the weight memory, dp_value back, busy/done/class_idx/
//                 max_value status, rd_addr/rd_data result buffer port)
// Rows are issued one per cycle; a DP_LATENCY-deep valid/row delay line tags
// each returning dp_value so capture works regardless of FSM state.
module vmp_row_scheduler #(
  parameter int N          = vmp_pkg::N_DEFAULT,
  parameter int PIXEL_N    = vmp_pkg::PIXEL_N_DEFAULT,
  parameter int PIXEL_SIZE = vmp_pkg::PIXEL_SIZE_DEFAULT,
  parameter int VAL_W      = vmp_pkg::VAL_W,
  parameter int DP_LATENCY = vmp_pkg::DP_LATENCY_DEFAULT,
  parameter int IDX_W      = $clog2(N)
) (
  input logic                 clk,
  input logic                 GlobalReset,
  vmp_row_scheduler_if.master bus
);
  import vmp_pkg::*;

  localparam int CNT_W = $clog2(N + 1);

  state_t                        state_reg, state_next;
  logic [IDX_W-1:0]              issue_cnt_reg;
  logic [CNT_W-1:0]              cap_cnt_reg, cap_cnt_next;
  logic [PIXEL_N*PIXEL_SIZE-1:0] pix_reg;
  logic [DP_LATENCY-1:0]         vld_pipe_reg;
  logic [IDX_W-1:0]              row_pipe_reg [DP_LATENCY];
  logic [IDX_W-1:0]              class_reg;
  logic signed [VAL_W-1:0]       max_reg;
  logic signed [VAL_W-1:0]       buf_reg [N];
  logic [N-1:0]                  wr_en;
  logic                          start_accept;
  logic                          capture;
  logic [IDX_W-1:0]              cap_row;
  logic [IDX_W-1:0]              best_idx;
  logic signed [VAL_W-1:0]       best_val;

  assign start_accept = (state_reg == IDLE) && bus.start;
  assign capture      = vld_pipe_reg[DP_LATENCY-1];
  assign cap_row      = row_pipe_reg[DP_LATENCY-1];
  assign bus.row_addr = issue_cnt_reg;
  assign bus.pix_out  = pix_reg;

  always_ff @(posedge clk) begin
    if (!GlobalReset) begin
      state_reg     <= IDLE;
      issue_cnt_reg <= '0;
      cap_cnt_reg   <= '0;
      pix_reg       <= '0;
      class_reg     <= '0;
      max_reg       <= '0;
    end else begin
      state_reg   <= state_next;
      cap_cnt_reg <= cap_cnt_next;
      if (start_accept) begin
        issue_cnt_reg <= '0;
        pix_reg       <= bus.Pixels;
      end else if (state_reg == ISSUE) begin
        issue_cnt_reg <= issue_cnt_reg + 1'b1;
      end
      if (state_reg == DONE) begin
        class_reg <= best_idx;
        max_reg   <= best_val;
      end
    end
  end

  // Capture count including this cycle's capture, so DRAIN can leave on the
  // same edge that stores the last row.
  always_comb begin
    cap_cnt_next = cap_cnt_reg;
    if (start_accept) begin
      cap_cnt_next = '0;
    end else if (capture) begin
      cap_cnt_next = cap_cnt_reg + 1'b1;
    end
  end

  always_comb begin
    state_next    = state_reg;
    bus.issue     = 1'b0;
    bus.busy      = 1'b1;
    bus.done      = 1'b0;
    bus.class_idx = class_reg;
    bus.max_value = max_reg;
    case (state_reg)
      IDLE: begin
        bus.busy = 1'b0;
        if (bus.start) state_next = ISSUE;
      end
      ISSUE: begin
        bus.issue = 1'b1;
        if (issue_cnt_reg == IDX_W'(N - 1)) state_next = DRAIN;
      end
      DRAIN: begin
        if (cap_cnt_next == CNT_W'(N)) state_next = DONE;
      end
      DONE: begin
        // Winner is visible in the done cycle itself, ahead of the holding registers.
        bus.done      = 1'b1;
        bus.class_idx = best_idx;
        bus.max_value = best_val;
        state_next    = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Delay line matching the weight-read plus DotProduct latency.
  always_ff @(posedge clk) begin
    if (!GlobalReset) begin
      vld_pipe_reg <= '0;
      for (int i = 0; i < DP_LATENCY; i++) row_pipe_reg[i] <= '0;
    end else begin
      vld_pipe_reg[0] <= (state_reg == ISSUE);
      row_pipe_reg[0] <= issue_cnt_reg;
      for (int i = 1; i < DP_LATENCY; i++) begin
        vld_pipe_reg[i] <= vld_pipe_reg[i-1];
        row_pipe_reg[i] <= row_pipe_reg[i-1];
      end
    end
  end

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_wr_en
      assign wr_en[gi] = capture && (cap_row == IDX_W'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!GlobalReset) begin
      for (int i = 0; i < N; i++) buf_reg[i] <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (wr_en[i]) buf_reg[i] <= bus.dp_value;
      end
    end
  end

  always_comb begin
    bus.rd_data = '0;
    if (int'(bus.rd_addr) < N) bus.rd_data = buf_reg[bus.rd_addr];
  end

  argmax_tracker #(
    .IDX_W(IDX_W),
    .VAL_W(VAL_W)
  ) u_argmax (
    .clk       (clk),
    .rst_n     (GlobalReset),
    .clear     (start_accept),
    .valid     (capture),
    .index     (cap_row),
    .value     (bus.dp_value),
    .best_index(best_idx),
    .best_value(best_val)
  );

endmodule

// File: tb/tb_vmp_row_scheduler.sv
// tb_vmp_row_scheduler: self-checking bench for vmp_row_scheduler.
// Three instances (DP_LATENCY 3, 1, 6) each fed by a behavioural weight/DotProduct
// model that returns tbl[row] DP_LATENCY cycles after the row is issued.
module tb_vmp_row_scheduler;
  localparam int N  = 10;
  localparam int PN = 10;
  localparam int PS = 10;
  localparam int VW = 26;
  localparam int IW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstn;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  vmp_row_scheduler_if #(.N(N), .PIXEL_N(PN), .PIXEL_SIZE(PS), .VAL_W(VW)) if3 ();
  vmp_row_scheduler_if #(.N(N), .PIXEL_N(PN), .PIXEL_SIZE(PS), .VAL_W(VW)) if1 ();
  vmp_row_scheduler_if #(.N(N), .PIXEL_N(PN), .PIXEL_SIZE(PS), .VAL_W(VW)) if6 ();

  vmp_row_scheduler #(.N(N), .PIXEL_N(PN), .PIXEL_SIZE(PS), .VAL_W(VW), .DP_LATENCY(3))
    u3 (.clk(clk), .GlobalReset(rstn), .bus(if3));
  vmp_row_scheduler #(.N(N), .PIXEL_N(PN), .PIXEL_SIZE(PS), .VAL_W(VW), .DP_LATENCY(1))
    u1 (.clk(clk), .GlobalReset(rstn), .bus(if1));
  vmp_row_scheduler #(.N(N), .PIXEL_N(PN), .PIXEL_SIZE(PS), .VAL_W(VW), .DP_LATENCY(6))
    u6 (.clk(clk), .GlobalReset(rstn), .bus(if6));

  // DotProduct model: row history, h[L-1] is the row issued L cycles ago.
  logic signed [VW-1:0] tbl [N];
  logic [IW-1:0] h3 [8];
  logic [IW-1:0] h1 [8];
  logic [IW-1:0] h6 [8];

  always @(posedge clk) begin
    h3[0] <= if3.row_addr;
    for (int i = 7; i > 0; i--) h3[i] <= h3[i-1];
  end
  always @(posedge clk) begin
    h1[0] <= if1.row_addr;
    for (int j = 7; j > 0; j--) h1[j] <= h1[j-1];
  end
  always @(posedge clk) begin
    h6[0] <= if6.row_addr;
    for (int m = 7; m > 0; m--) h6[m] <= h6[m-1];
  end

  always_comb if3.dp_value = (h3[2] < IW'(N)) ? tbl[h3[2]] : '0;
  always_comb if1.dp_value = (h1[0] < IW'(N)) ? tbl[h1[0]] : '0;
  always_comb if6.dp_value = (h6[5] < IW'(N)) ? tbl[h6[5]] : '0;

  typedef struct {
    int     cls;
    longint mx;
    int     cyc;
  } exp_t;
  exp_t sb_q[$];

  typedef struct {
    int     kind;
    int     cls;
    longint mx;
    int     rd_a;
    longint rd_exp;
  } vec_t;
  vec_t vecs [7];

  int w_issue, w_done, w_d0, w_d1, w_r1;
  logic [99:0] alt_pix;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic chk_wide(input string name, input logic [99:0] act, input logic [99:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic fill_tbl(input int kind);
    for (int k = 0; k < N; k++) begin
      int v;
      case (kind)
        0: v = (k + 1) * 100;
        1: v = (k == 3 || k == 7) ? 20 : -50;
        2: v = (k == 5) ? -1 : -9;
        3: v = 1000 - 100 * k;
        4: v = 7;
        5: v = (k == 9) ? 6 : 5;
        default: v = (k == 2) ? 33554431 : -33554432;
      endcase
      tbl[k] = VW'(v);
    end
  endtask

  function automatic logic get_issue(input int s);
    case (s)
      0: return if3.issue;
      1: return if1.issue;
      default: return if6.issue;
    endcase
  endfunction

  function automatic logic get_done(input int s);
    case (s)
      0: return if3.done;
      1: return if1.done;
      default: return if6.done;
    endcase
  endfunction

  function automatic logic get_busy(input int s);
    case (s)
      0: return if3.busy;
      1: return if1.busy;
      default: return if6.busy;
    endcase
  endfunction

  function automatic int get_class(input int s);
    case (s)
      0: return int'(if3.class_idx);
      1: return int'(if1.class_idx);
      default: return int'(if6.class_idx);
    endcase
  endfunction

  function automatic longint get_max(input int s);
    case (s)
      0: return longint'(if3.max_value);
      1: return longint'(if1.max_value);
      default: return longint'(if6.max_value);
    endcase
  endfunction

  task automatic set_start(input int s, input logic v);
    case (s)
      0: if3.start = v;
      1: if1.start = v;
      default: if6.start = v;
    endcase
  endtask

  task automatic set_pix(input int s, input logic [99:0] p);
    case (s)
      0: if3.Pixels = p;
      1: if1.Pixels = p;
      default: if6.Pixels = p;
    endcase
  endtask

  function automatic logic [99:0] rand_pix();
    logic [127:0] r;
    r = {$urandom(), $urandom(), $urandom(), $urandom()};
    return r[99:0];
  endfunction

  // Starts a pass at the next edge (cycle 0) and watches `win` cycles.
  // start stays high for cycles < drop; optional busy-time start pulse,
  // one-cycle reset, and model table swap at given cycles (-1 = none).
  task automatic run_window(input int sel, input int win, input int drop, input int pulse,
                            input int rstc, input int swap_cyc, input int swap_kind,
                            input logic [99:0] pix);
    logic prev;
    logic is_i;
    logic dn;
    int   rises;
    exp_t e;
    w_issue = 0; w_done = 0; w_d0 = -1; w_d1 = -1; w_r1 = -1;
    rises = 0; prev = 1'b0;
    @(negedge clk);
    set_pix(sel, pix);
    set_start(sel, 1'b1);
    for (int c = 1; c <= win; c++) begin
      @(negedge clk);
      is_i = get_issue(sel);
      dn   = get_done(sel);
      if (c == 1) chk("busy_cycle1", longint'(get_busy(sel)), 1);
      if (is_i) w_issue++;
      if (is_i && !prev) begin
        rises++;
        if (rises == 2) w_r1 = c;
      end
      prev = is_i;
      if (dn) begin
        w_done++;
        if (w_done == 1) w_d0 = c;
        else if (w_done == 2) w_d1 = c;
        $display("pass inst=%0d done cycle=%0d class_idx=%0d max_value=%0d",
                 sel, c, get_class(sel), get_max(sel));
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done actual=done_at_cycle_%0d required=no_done", c);
        end else begin
          e = sb_q.pop_front();
          chk("done_cycle", c, e.cyc);
          chk("class_idx", get_class(sel), e.cls);
          chk("max_value", get_max(sel), e.mx);
        end
      end
      if (rstc >= 0 && c == rstc) chk("buf0_before_reset", longint'(if3.rd_data), longint'(tbl[0]));
      if (rstc >= 0 && c == rstc + 1) begin
        chk("busy_after_reset", longint'(get_busy(sel)), 0);
        chk("issue_after_reset", longint'(is_i), 0);
        chk("class_after_reset", get_class(sel), 0);
        chk("buf0_after_reset", longint'(if3.rd_data), 0);
      end
      set_start(sel, (c < drop) || (c == pulse));
      if (c == pulse) set_pix(sel, alt_pix);
      rstn = (c == rstc) ? 1'b0 : 1'b1;
      if (c == swap_cyc) fill_tbl(swap_kind);
    end
    set_start(sel, 1'b0);
    rstn = 1'b1;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      checks++;
      failures++;
      $display("FAIL missing_done actual=no_done required=done_at_cycle_%0d", e.cyc);
    end
  endtask

  initial begin
    logic [99:0] pix;

    vecs[0] = '{0, 9, 1000, 4, 500};
    vecs[1] = '{1, 3, 20, 7, 20};
    vecs[2] = '{2, 5, -1, 0, -9};
    vecs[3] = '{3, 0, 1000, 9, 100};
    vecs[4] = '{4, 0, 7, 12, 0};
    vecs[5] = '{5, 9, 6, 3, 5};
    vecs[6] = '{6, 2, 33554431, 2, 33554431};

    rstn = 1'b0;
    if3.start = 1'b0; if1.start = 1'b0; if6.start = 1'b0;
    if3.Pixels = '0;  if1.Pixels = '0;  if6.Pixels = '0;
    if3.rd_addr = '0; if1.rd_addr = '0; if6.rd_addr = '0;
    fill_tbl(0);
    repeat (3) @(negedge clk);

    chk("reset_busy", longint'(if3.busy), 0);
    chk("reset_done", longint'(if3.done), 0);
    chk("reset_issue", longint'(if3.issue), 0);
    chk("reset_class", int'(if3.class_idx), 0);
    chk("reset_max", longint'(if3.max_value), 0);
    chk("reset_rd0", longint'(if3.rd_data), 0);
    chk_wide("reset_pix_out", if3.pix_out, '0);
    rstn = 1'b1;

    // Table-driven single passes.
    for (int i = 0; i < 7; i++) begin
      fill_tbl(vecs[i].kind);
      pix = rand_pix();
      sb_q.push_back('{vecs[i].cls, vecs[i].mx, 14});
      run_window(0, 18, 1, -1, -1, -1, 0, pix);
      chk("done_count", w_done, 1);
      chk("issue_count", w_issue, N);
      chk_wide("pix_out", if3.pix_out, pix);
      if3.rd_addr = IW'(vecs[i].rd_a);
      #1;
      chk("rd_data", longint'(if3.rd_data), vecs[i].rd_exp);
      if3.rd_addr = '0;
    end

    // Start pulse while busy: ignored.
    fill_tbl(0);
    pix = rand_pix();
    alt_pix = ~pix;
    sb_q.push_back('{9, 1000, 14});
    run_window(0, 18, 1, 5, -1, -1, 0, pix);
    chk("busy_start_done_count", w_done, 1);
    chk_wide("busy_start_pix_out", if3.pix_out, pix);

    // Reset during cycle 6 of a pass.
    fill_tbl(0);
    if3.rd_addr = '0;
    run_window(0, 16, 1, -1, 6, -1, 0, rand_pix());
    chk("reset_pass_done_count", w_done, 0);
    chk("reset_pass_issue_count", w_issue, 6);
    chk("reset_pass_class", int'(if3.class_idx), 0);
    chk("reset_pass_max", longint'(if3.max_value), 0);
    chk_wide("reset_pass_pix_out", if3.pix_out, '0);
    if3.rd_addr = IW'(3);
    #1;
    chk("reset_pass_rd3", longint'(if3.rd_data), 0);
    if3.rd_addr = IW'(5);
    #1;
    chk("reset_pass_rd5", longint'(if3.rd_data), 0);

    // Normal pass after reset.
    fill_tbl(5);
    sb_q.push_back('{9, 6, 14});
    run_window(0, 18, 1, -1, -1, -1, 0, rand_pix());
    chk("post_reset_done_count", w_done, 1);
    if3.rd_addr = IW'(3);
    #1;
    chk("post_reset_rd3", longint'(if3.rd_data), 5);

    // Back-to-back passes with start held high; pass 2 sees a different table.
    fill_tbl(0);
    sb_q.push_back('{9, 1000, 14});
    sb_q.push_back('{3, 20, 29});
    run_window(0, 34, 16, -1, -1, 15, 1, rand_pix());
    chk("b2b_done_count", w_done, 2);
    chk("b2b_done_spacing", w_d1 - w_d0, 15);
    chk("b2b_second_issue_cycle", w_r1, 16);
    chk("b2b_issue_count", w_issue, 2 * N);
    if3.rd_addr = IW'(4);
    #1;
    chk("b2b_rd4", longint'(if3.rd_data), -50);
    if3.rd_addr = IW'(3);
    #1;
    chk("b2b_rd3", longint'(if3.rd_data), 20);

    // Latency sweep.
    fill_tbl(0);
    sb_q.push_back('{9, 1000, 12});
    run_window(1, 18, 1, -1, -1, -1, 0, rand_pix());
    chk("lat1_done_count", w_done, 1);
    chk("lat1_issue_count", w_issue, N);
    sb_q.push_back('{9, 1000, 17});
    run_window(2, 22, 1, -1, -1, -1, 0, rand_pix());
    chk("lat6_done_count", w_done, 1);
    chk("lat6_issue_count", w_issue, N);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
